// File: rtl/led_frame_receiver.sv
// led_frame_receiver
//
// Receives a serial stream of BCD digit nibbles, most significant digit
// first, and converts each complete frame into both a packed BCD word and
// its binary value. A low strobe on cclr_neg (re)synchronises the receiver.
// After the strobe is released, one settle cycle is skipped. The following
// NUM_DIGITS samples form a frame. Further frames follow back to back until
// the next strobe.
//
// Ports
//   clk_out      sampling clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   cclr_neg     active-low frame clear / resync strobe
//   num[3:0]     serial digit nibble
//   value[31:0]  binary value of the last good frame
//   bcd[31:0]    packed BCD of the last good frame (bcd[31:28] = first digit)
//   frame_valid  one-cycle pulse when value/bcd update
//   bcd_err      one-cycle pulse when a frame is rejected (digit > 9)
//   synced       high while receiving (state RECV)
//
// NUM_DIGITS is fixed at 8 in this release. The 32-bit outputs and the
// 3-bit position counter assume that value.

module led_frame_receiver #(
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk_out,
  input  logic        rst,
  input  logic        cclr_neg,
  input  logic [3:0]  num,
  output logic [31:0] value,
  output logic [31:0] bcd,
  output logic        frame_valid,
  output logic        bcd_err,
  output logic        synced
);

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    SKIP   = 2'd1,
    RECV   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_POS = 3'(NUM_DIGITS - 1);

  state_t      state;
  logic [2:0]  pos;
  logic [31:0] acc;
  logic [31:0] shift_reg;
  logic        err_flag;

  logic [31:0] acc_next;
  logic [31:0] shift_next;
  logic        digit_bad;

  // acc*10 + num built from shifts and adds. The largest legal frame,
  // 99,999,999, fits in 32 bits, so no overflow handling is needed.
  always_comb begin
    acc_next   = (acc << 3) + (acc << 1) + {28'd0, num};
    shift_next = {shift_reg[27:0], num};
    digit_bad  = (num > 4'd9);
  end

  always_ff @(posedge clk_out) begin
    // The two status pulses default low, so each lasts exactly one cycle.
    frame_valid <= 1'b0;
    bcd_err     <= 1'b0;

    if (rst) begin
      state     <= UNSYNC;
      pos       <= 3'd0;
      acc       <= 32'd0;
      shift_reg <= 32'd0;
      err_flag  <= 1'b0;
      value     <= 32'd0;
      bcd       <= 32'd0;
      synced    <= 1'b0;
    end else begin
      case (state)
        UNSYNC: begin
          if (!cclr_neg) begin
            state <= SKIP;
          end
        end

        SKIP: begin
          pos       <= 3'd0;
          acc       <= 32'd0;
          shift_reg <= 32'd0;
          err_flag  <= 1'b0;
          // The first sample after the strobe is the transmitter's
          // settle cycle, so num is not captured on this edge.
          if (cclr_neg) begin
            state  <= RECV;
            synced <= 1'b1;
          end
        end

        RECV: begin
          if (!cclr_neg) begin
            // A resync mid-frame drops the partial frame without any pulse.
            state     <= SKIP;
            synced    <= 1'b0;
            pos       <= 3'd0;
            acc       <= 32'd0;
            shift_reg <= 32'd0;
            err_flag  <= 1'b0;
          end else if (pos == LAST_POS) begin
            // The last digit is checked here as well as the sticky flag,
            // because the flag would only see this digit one edge too late.
            if (!err_flag && !digit_bad) begin
              value       <= acc_next;
              bcd         <= shift_next;
              frame_valid <= 1'b1;
            end else begin
              bcd_err <= 1'b1;
            end
            pos       <= 3'd0;
            acc       <= 32'd0;
            shift_reg <= 32'd0;
            err_flag  <= 1'b0;
          end else begin
            pos       <= pos + 3'd1;
            acc       <= acc_next;
            shift_reg <= shift_next;
            err_flag  <= err_flag | digit_bad;
          end
        end

        default: begin
          state  <= UNSYNC;
          synced <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_receiver.sv
// tb_led_frame_receiver
//
// Directed bench for led_frame_receiver. The stimulus process pushes each
// expected pulse into a queue, together with its contents and the edge it
// must follow. A separate monitor pops and compares each pulse the DUT
// produces, at the falling edge.

module tb_led_frame_receiver;

  logic        clk_out = 1'b0;
  logic        rst = 1'b1;
  logic        cclr_neg = 1'b1;
  logic [3:0]  num = 4'd0;
  logic [31:0] value;
  logic [31:0] bcd;
  logic        frame_valid;
  logic        bcd_err;
  logic        synced;

  led_frame_receiver #(.NUM_DIGITS(8)) dut (
    .clk_out     (clk_out),
    .rst         (rst),
    .cclr_neg    (cclr_neg),
    .num         (num),
    .value       (value),
    .bcd         (bcd),
    .frame_valid (frame_valid),
    .bcd_err     (bcd_err),
    .synced      (synced)
  );

  always #5 clk_out = ~clk_out;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    logic [31:0] bcd;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] last_val = 32'd0;
  logic [31:0] last_bcd = 32'd0;

  always @(posedge clk_out) cyc <= cyc + 1;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one sample. On return the sampling edge has passed, and cyc
  // holds that edge's index.
  task automatic applyStimulus(input logic r, input logic c, input logic [3:0] n);
    rst      = r;
    cclr_neg = c;
    num      = n;
    @(posedge clk_out);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] ev, input logic [31:0] eb,
                             input logic es);
    checkEq({tag, "_value"}, value, ev);
    checkEq({tag, "_bcd"}, bcd, eb);
    checkEq({tag, "_synced"}, {31'd0, synced}, {31'd0, es});
  endtask

  task automatic syncUp();
    applyStimulus(1'b0, 1'b0, 4'h3);
    applyStimulus(1'b0, 1'b1, 4'h7);
  endtask

  // Send eight digits taken from a packed nibble word. A good frame
  // expects frame_valid carrying exp_val/digits. A bad frame expects
  // bcd_err with the previous outputs unchanged.
  task automatic sendFrame(input logic [31:0] digits, input bit good, input logic [31:0] exp_val);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, digits[31-4*i -: 4]);
    end
    e.is_err = !good;
    e.cyc    = cyc;
    if (good) begin
      last_val = exp_val;
      last_bcd = digits;
    end
    e.val = last_val;
    e.bcd = last_bcd;
    sbq.push_back(e);
  endtask

  // The monitor samples each pulse at the falling edge.
  logic prev_fv = 1'b0;
  logic prev_be = 1'b0;
  always @(negedge clk_out) begin
    exp_t e;
    if (frame_valid && bcd_err) begin
      checks++;
      failures++;
      $display("[TB] FAIL both_pulses: frame_valid=1 bcd_err=1 expected not both (cycle %0d)", cyc);
    end
    if ((frame_valid && prev_fv) || (bcd_err && prev_be)) begin
      checks++;
      failures++;
      $display("[TB] FAIL pulse_width: pulse held 2 cycles expected 1 (cycle %0d)", cyc);
    end
    if (frame_valid || bcd_err) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_pulse: fv=%0b err=%0b expected none (cycle %0d)",
                 frame_valid, bcd_err, cyc);
      end else begin
        e = sbq.pop_front();
        checkEq("pulse_kind_err", {31'd0, bcd_err}, {31'd0, e.is_err});
        checkEq("pulse_cycle", cyc, e.cyc);
        checkEq("pulse_value", value, e.val);
        checkEq("pulse_bcd", bcd, e.bcd);
      end
    end
    prev_fv = frame_valid;
    prev_be = bcd_err;
  end

  initial begin
    // Reset, with the strobe and digits driven to show that reset wins.
    applyStimulus(1'b1, 1'b0, 4'h9);
    applyStimulus(1'b1, 1'b0, 4'h9);
    checkOutput("reset", 32'd0, 32'd0, 1'b0);
    checkEq("reset_fv", {31'd0, frame_valid}, 32'd0);
    checkEq("reset_err", {31'd0, bcd_err}, 32'd0);

    // Without a strobe after reset, digits are ignored.
    applyStimulus(1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 4'(i % 10));
    checkOutput("unsync", 32'd0, 32'd0, 1'b0);

    // Basic frame, then a back-to-back zero frame and an all-nines frame.
    syncUp();
    checkEq("synced_after_settle", {31'd0, synced}, 32'd1);
    sendFrame(32'h12345678, 1'b1, 32'd12345678);
    sendFrame(32'h00000000, 1'b1, 32'd0);
    sendFrame(32'h99999999, 1'b1, 32'd99999999);
    #1;
    checkOutput("nines", 32'd99999999, 32'h99999999, 1'b1);

    // An illegal nibble at position 3 and an illegal nibble on the last digit.
    sendFrame(32'h123A5678, 1'b0, 32'd0);
    sendFrame(32'h1234567F, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("after_err", 32'd99999999, 32'h99999999, 1'b1);
    // The receiver re-aligns here with a fresh strobe, because the extra
    // sample above started a new frame.

    // A partial frame is discarded by the strobe, then 420 is received.
    syncUp();
    applyStimulus(1'b0, 1'b1, 4'h5);
    applyStimulus(1'b0, 1'b1, 4'h5);
    applyStimulus(1'b0, 1'b1, 4'h5);
    applyStimulus(1'b0, 1'b0, 4'h5);
    checkEq("resync_synced", {31'd0, synced}, 32'd0);
    applyStimulus(1'b0, 1'b1, 4'h1);
    sendFrame(32'h00000420, 1'b1, 32'd420);
    #1;
    checkOutput("f420", 32'd420, 32'h00000420, 1'b1);

    // Reset at position 5, then digits without a strobe give no output.
    syncUp();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'(i + 1));
    applyStimulus(1'b1, 1'b1, 4'h6);
    checkOutput("mid_reset", 32'd0, 32'd0, 1'b0);
    last_val = 32'd0;
    last_bcd = 32'd0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 4'(i % 10));
    checkOutput("post_reset", 32'd0, 32'd0, 1'b0);

    // Normal operation resumes once a strobe is seen again.
    syncUp();
    sendFrame(32'h87654321, 1'b1, 32'd87654321);
    applyStimulus(1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b1, 4'h0);
    checkOutput("final", 32'd87654321, 32'h87654321, 1'b1);

    checkEq("scoreboard_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
